// File: rtl/temp_uart_reporter.sv
`timescale 1ns / 1ps
// temp_uart_reporter
//
// Sends each new DHT11 temperature reading to a host terminal as three ASCII
// decimal digits followed by CR LF on a UART 8N1 line.
//
// Data path:
//   trigger detector -> one-deep pending buffer -> sequential bin-to-decimal
//   converter -> baud-timed serializer.
//
// Parameters:
//   CLKS_PER_BIT : clock cycles per UART bit. Legal range is 2..65535.
//
// Ports:
//   clk         : system clock. All logic runs on the rising edge.
//   rst         : asynchronous, active-high reset.
//   temperature : unsigned 8-bit reading from the reader.
//   data_valid  : reader valid level. It may stay high indefinitely.
//   tx          : UART serial line. Idles high.
//   busy        : high while a message is converting or transmitting.
//   overrun     : one-cycle pulse when a pending reading is overwritten.
module temp_uart_reporter #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] temperature,
  input  logic       data_valid,
  output logic       tx,
  output logic       busy,
  output logic       overrun
);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StConvert = 3'd1;
  localparam logic [2:0] StStart   = 3'd2;
  localparam logic [2:0] StData    = 3'd3;
  localparam logic [2:0] StStop    = 3'd4;

  localparam logic [15:0] BaudMax = 16'(CLKS_PER_BIT - 1);

  // Trigger detector and pending buffer
  logic       r_dv_q;
  logic [7:0] r_last_cap;
  logic [7:0] r_pend_val;
  logic       r_pend_full;

  // Converter and serializer
  logic [2:0]  r_state;
  logic [7:0]  r_work;      // remainder during conversion, ones digit afterwards
  logic [1:0]  r_hund;
  logic [3:0]  r_tens;
  logic [15:0] r_baud_cnt;
  logic [2:0]  r_bit_idx;
  logic [2:0]  r_byte_idx;
  logic        r_tx;

  logic [2:0]  w_state_d;
  logic [7:0]  w_work_d;
  logic [1:0]  w_hund_d;
  logic [3:0]  w_tens_d;
  logic [15:0] w_baud_d;
  logic [2:0]  w_bit_d;
  logic [2:0]  w_byte_d;
  logic [7:0]  w_cur_byte;
  logic        w_tx_d;

  logic w_event;
  logic w_consume;
  logic w_baud_done;

  // A reading is new on a rising edge of data_valid, or when the value moves
  // while data_valid is held high.
  assign w_event     = data_valid & (~r_dv_q | (temperature != r_last_cap));
  assign w_consume   = (r_state == StIdle) & r_pend_full;
  assign w_baud_done = (r_baud_cnt == BaudMax);

  // Overwrite of an unconsumed reading. A refill in the consume cycle is not
  // an overrun because the old value has just been taken.
  assign overrun = w_event & r_pend_full & ~w_consume;
  assign busy    = (r_state != StIdle);
  assign tx      = r_tx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dv_q      <= 1'b0;
      r_last_cap  <= 8'd0;
      r_pend_val  <= 8'd0;
      r_pend_full <= 1'b0;
    end else begin
      r_dv_q <= data_valid;
      if (w_event) begin
        r_pend_val  <= temperature;
        r_pend_full <= 1'b1;
        r_last_cap  <= temperature;
      end else if (w_consume) begin
        r_pend_full <= 1'b0;
      end
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_work_d  = r_work;
    w_hund_d  = r_hund;
    w_tens_d  = r_tens;
    w_baud_d  = r_baud_cnt;
    w_bit_d   = r_bit_idx;
    w_byte_d  = r_byte_idx;

    case (r_state)
      StIdle: begin
        if (r_pend_full) begin
          w_work_d  = r_pend_val;
          w_hund_d  = 2'd0;
          w_tens_d  = 4'd0;
          w_byte_d  = 3'd0;
          w_state_d = StConvert;
        end
      end

      // One subtraction per cycle. Hundreds are exhausted before tens, so the
      // tens branch only ever sees a value below 100.
      StConvert: begin
        if (r_work >= 8'd100) begin
          w_work_d = r_work - 8'd100;
          w_hund_d = r_hund + 2'd1;
        end else if (r_work >= 8'd10) begin
          w_work_d = r_work - 8'd10;
          w_tens_d = r_tens + 4'd1;
        end else begin
          w_baud_d  = 16'd0;
          w_state_d = StStart;
        end
      end

      StStart: begin
        if (w_baud_done) begin
          w_baud_d  = 16'd0;
          w_bit_d   = 3'd0;
          w_state_d = StData;
        end else begin
          w_baud_d = r_baud_cnt + 16'd1;
        end
      end

      StData: begin
        if (w_baud_done) begin
          w_baud_d = 16'd0;
          if (r_bit_idx == 3'd7) begin
            w_state_d = StStop;
          end else begin
            w_bit_d = r_bit_idx + 3'd1;
          end
        end else begin
          w_baud_d = r_baud_cnt + 16'd1;
        end
      end

      // Next start bit follows the stop bit with no idle gap.
      StStop: begin
        if (w_baud_done) begin
          w_baud_d = 16'd0;
          if (r_byte_idx == 3'd4) begin
            w_state_d = StIdle;
          end else begin
            w_byte_d  = r_byte_idx + 3'd1;
            w_state_d = StStart;
          end
        end else begin
          w_baud_d = r_baud_cnt + 16'd1;
        end
      end

      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  // Byte of the message selected by the next-cycle byte index. Leading zeros
  // are kept so every message has exactly three digits.
  always_comb begin
    w_cur_byte = 8'h0A;
    case (w_byte_d)
      3'd0:    w_cur_byte = 8'h30 + {6'd0, w_hund_d};
      3'd1:    w_cur_byte = 8'h30 + {4'd0, w_tens_d};
      3'd2:    w_cur_byte = 8'h30 + {4'd0, w_work_d[3:0]};
      3'd3:    w_cur_byte = 8'h0D;
      default: w_cur_byte = 8'h0A;
    endcase
  end

  // tx is registered from the next state so the line never glitches.
  always_comb begin
    w_tx_d = 1'b1;
    case (w_state_d)
      StStart: w_tx_d = 1'b0;
      StData:  w_tx_d = w_cur_byte[w_bit_d];
      default: w_tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StIdle;
      r_work     <= 8'd0;
      r_hund     <= 2'd0;
      r_tens     <= 4'd0;
      r_baud_cnt <= 16'd0;
      r_bit_idx  <= 3'd0;
      r_byte_idx <= 3'd0;
      r_tx       <= 1'b1;
    end else begin
      r_state    <= w_state_d;
      r_work     <= w_work_d;
      r_hund     <= w_hund_d;
      r_tens     <= w_tens_d;
      r_baud_cnt <= w_baud_d;
      r_bit_idx  <= w_bit_d;
      r_byte_idx <= w_byte_d;
      r_tx       <= w_tx_d;
    end
  end

endmodule
